// File: rtl/hv_wdg_ctrl_pkg.sv
// Shared parameters and types for the HV-side watchdog responder.
package hv_wdg_ctrl_pkg;

    // Timeout thresholds in clock cycles, selected by i_wdgtmo_config (index 0 = 500).
    localparam logic [3:0][15:0] HV_WDG_TIMEOUT_TH = {16'd4000, 16'd2000, 16'd1000, 16'd500};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2,
        ST_RSP  = 2'd3
    } hv_wdg_st_e;

    function automatic logic [2:0] err_sat_inc(input logic [2:0] value);
        return (value == 3'd7) ? value : value + 3'd1;
    endfunction

endpackage

// File: rtl/hv_wdg_ctrl.sv
// HV watchdog responder: checks LV watchdog frame timing, answers valid frames
// after a turnaround gap, and escalates repeated errors to a sticky comm-fail.
module hv_wdg_ctrl
    import hv_wdg_ctrl_pkg::*;
#(
    parameter int WDG_CNT_W   = 16,
    parameter int RSP_GAP_CYC = 4,
    parameter int ERR_CNT_TH  = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wdg_en,
    input  logic [1:0] i_wdgtmo_config,
    input  logic       i_owt_rx_wdg_req,
    input  logic       i_owt_rx_crc_err,
    output logic       o_wdg_owt_tx_rsp_req,
    input  logic       i_owt_tx_wdg_rsp_ack,
    output logic       o_wdg_timeout_err,
    output logic       o_wdg_comm_fail,
    input  logic       i_clr_comm_fail
);

    localparam logic [3:0] GAP_LAST = 4'(RSP_GAP_CYC - 1);
    localparam logic [2:0] ERR_TH   = 3'(ERR_CNT_TH);

    hv_wdg_st_e           state, state_nxt;
    logic [WDG_CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]           gap_cnt, gap_nxt;
    logic [2:0]           err_cnt, err_nxt;
    logic                 rsp_req_nxt, tmo_err_nxt, comm_fail_nxt;

    logic [WDG_CNT_W-1:0] th_m1;
    logic                 frame_ok, frame_bad, tmo_evt;

    // Threshold follows the live config; a count already past it simply wraps with no event.
    assign th_m1     = WDG_CNT_W'(HV_WDG_TIMEOUT_TH[i_wdgtmo_config]) - WDG_CNT_W'(1);
    assign frame_ok  = i_owt_rx_wdg_req & ~i_owt_rx_crc_err;
    assign frame_bad = i_owt_rx_wdg_req & i_owt_rx_crc_err;
    assign tmo_evt   = (cnt == th_m1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            gap_cnt              <= '0;
            err_cnt              <= '0;
            o_wdg_owt_tx_rsp_req <= 1'b0;
            o_wdg_timeout_err    <= 1'b0;
            o_wdg_comm_fail      <= 1'b0;
        end else begin
            state                <= state_nxt;
            cnt                  <= cnt_nxt;
            gap_cnt              <= gap_nxt;
            err_cnt              <= err_nxt;
            o_wdg_owt_tx_rsp_req <= rsp_req_nxt;
            o_wdg_timeout_err    <= tmo_err_nxt;
            o_wdg_comm_fail      <= comm_fail_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        gap_nxt       = gap_cnt;
        err_nxt       = err_cnt;
        rsp_req_nxt   = o_wdg_owt_tx_rsp_req;
        tmo_err_nxt   = o_wdg_timeout_err;
        comm_fail_nxt = o_wdg_comm_fail;

        if (!i_wdg_en) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            gap_nxt     = '0;
            err_nxt     = '0;
            rsp_req_nxt = 1'b0;
            tmo_err_nxt = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: state_nxt = ST_WAIT;
                ST_WAIT: begin
                    // A good frame takes priority over a coincident timeout.
                    if (frame_ok) begin
                        cnt_nxt     = '0;
                        tmo_err_nxt = 1'b0;
                        err_nxt     = '0;
                        gap_nxt     = '0;
                        state_nxt   = ST_GAP;
                    end else begin
                        if (tmo_evt) begin
                            cnt_nxt     = '0;
                            tmo_err_nxt = 1'b1;
                        end else begin
                            cnt_nxt = cnt + WDG_CNT_W'(1);
                        end
                        if (tmo_evt || frame_bad) begin
                            err_nxt = err_sat_inc(err_cnt);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_nxt     = '0;
                        rsp_req_nxt = 1'b1;
                        state_nxt   = ST_RSP;
                    end else begin
                        gap_nxt = gap_cnt + 4'd1;
                    end
                end
                ST_RSP: begin
                    if (i_owt_tx_wdg_rsp_ack) begin
                        rsp_req_nxt = 1'b0;
                        cnt_nxt     = '0;
                        state_nxt   = ST_WAIT;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Looking at the next error count makes comm-fail rise together with the counter.
        if (err_nxt >= ERR_TH) begin
            comm_fail_nxt = 1'b1;
        end else if (i_clr_comm_fail) begin
            comm_fail_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_hv_wdg_ctrl.sv
// Self-checking bench for hv_wdg_ctrl: directed scenarios plus a random phase,
// all compared cycle by cycle against a timestamp-based reference model.
module tb_hv_wdg_ctrl;

    localparam int RSP_GAP_CYC = 4;
    localparam int ERR_CNT_TH  = 3;
    localparam int TH_TABLE [4] = '{500, 1000, 2000, 4000};

    logic       i_clk = 1'b0;
    logic       rst_n;
    logic       wdg_en;
    logic [1:0] wdgtmo_config;
    logic       rx_req;
    logic       rx_crc_err;
    logic       rsp_req;
    logic       rsp_ack;
    logic       timeout_err;
    logic       comm_fail;
    logic       clr_comm_fail;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: response timing kept as an absolute cycle stamp.
    int cyc;
    bit m_on, m_busy, m_req, m_tmo, m_fail;
    int m_rsp_at, m_cnt, m_err;

    always #5 i_clk = ~i_clk;

    hv_wdg_ctrl #(
        .WDG_CNT_W   (16),
        .RSP_GAP_CYC (RSP_GAP_CYC),
        .ERR_CNT_TH  (ERR_CNT_TH)
    ) dut (
        .i_clk                (i_clk),
        .i_rst_n              (rst_n),
        .i_wdg_en             (wdg_en),
        .i_wdgtmo_config      (wdgtmo_config),
        .i_owt_rx_wdg_req     (rx_req),
        .i_owt_rx_crc_err     (rx_crc_err),
        .o_wdg_owt_tx_rsp_req (rsp_req),
        .i_owt_tx_wdg_rsp_ack (rsp_ack),
        .o_wdg_timeout_err    (timeout_err),
        .o_wdg_comm_fail      (comm_fail),
        .i_clr_comm_fail      (clr_comm_fail)
    );

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".rsp_req"},   32'(rsp_req),     32'(m_req));
        checkValue({tag, ".tmo_err"},   32'(timeout_err), 32'(m_tmo));
        checkValue({tag, ".comm_fail"}, 32'(comm_fail),   32'(m_fail));
        checkValue({tag, ".err_cnt"},   32'(dut.err_cnt), 32'(m_err));
        checkValue({tag, ".cnt"},       32'(dut.cnt),     32'(m_cnt));
    endtask

    task automatic modelReset();
        m_on = 0; m_busy = 0; m_req = 0; m_tmo = 0; m_fail = 0;
        m_cnt = 0; m_err = 0; m_rsp_at = 0;
    endtask

    task automatic modelStep();
        int th;
        bit hit;
        th = TH_TABLE[wdgtmo_config];
        if (!wdg_en) begin
            m_on = 0; m_busy = 0; m_cnt = 0; m_err = 0; m_tmo = 0;
        end else if (!m_on) begin
            m_on = 1;
        end else if (m_busy) begin
            if (m_req && rsp_ack) begin
                m_busy = 0;
                m_cnt  = 0;
            end
        end else if (rx_req && !rx_crc_err) begin
            m_busy   = 1;
            m_rsp_at = cyc + 1 + RSP_GAP_CYC;
            m_cnt    = 0;
            m_tmo    = 0;
            m_err    = 0;
        end else begin
            hit   = (m_cnt == th - 1);
            m_cnt = hit ? 0 : (m_cnt + 1) % 65536;
            if (hit) m_tmo = 1;
            if (hit || rx_req) m_err = (m_err < 7) ? m_err + 1 : 7;
        end
        cyc++;
        m_req = m_busy && (cyc >= m_rsp_at);
        if (m_err >= ERR_CNT_TH) m_fail = 1;
        else if (clr_comm_fail)  m_fail = 0;
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] cfg, input logic rx,
                                 input logic crc, input logic ack, input logic clr);
        @(negedge i_clk);
        wdg_en        = en;
        wdgtmo_config = cfg;
        rx_req        = rx;
        rx_crc_err    = crc;
        rsp_ack       = ack;
        clr_comm_fail = clr;
        @(posedge i_clk);
        modelStep();
        #1;
        checkOutput("step");
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(wdg_en, wdgtmo_config, 0, 0, 0, 0);
    endtask

    task automatic releaseReset();
        @(negedge i_clk);
        rst_n = 1'b1;
        @(posedge i_clk);
        modelStep();
        #1;
        checkOutput("post_reset");
    endtask

    task automatic frameAndAck();
        applyStimulus(1, wdgtmo_config, 1, 0, 0, 0);
        runIdle(RSP_GAP_CYC);
        applyStimulus(1, wdgtmo_config, 0, 0, 1, 0);
    endtask

    initial begin
        int rises;
        bit prev_req;
        rst_n = 1'b0; wdg_en = 0; wdgtmo_config = 0;
        rx_req = 0; rx_crc_err = 0; rsp_ack = 0; clr_comm_fail = 0;
        cyc = 0;
        modelReset();
        #3;
        checkValue("reset_req",  32'(rsp_req),     0);
        checkValue("reset_tmo",  32'(timeout_err), 0);
        checkValue("reset_fail", 32'(comm_fail),   0);
        releaseReset();

        // Timeouts with config 0 and escalation to comm-fail.
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 500; i++) begin
            runIdle(1);
            if (i == 499) checkValue("tmo_before_500", 32'(timeout_err), 0);
            if (i == 500) checkValue("tmo_at_500", 32'(timeout_err), 1);
        end
        checkValue("err_after_1_tmo", 32'(dut.err_cnt), 1);
        for (int i = 1; i <= 1000; i++) begin
            runIdle(1);
            if (i == 999)  checkValue("fail_before_3rd", 32'(comm_fail), 0);
            if (i == 1000) checkValue("fail_after_3rd", 32'(comm_fail), 1);
        end

        // Valid frame at N: request at N+5, ack at N+8, request gone at N+9.
        applyStimulus(1, 0, 1, 0, 0, 0);
        checkValue("tmo_clr_on_frame", 32'(timeout_err), 0);
        for (int k = 1; k <= 4; k++) begin
            runIdle(1);
            checkValue("rsp_timing", 32'(rsp_req), (k == 4) ? 1 : 0);
        end
        runIdle(3);
        applyStimulus(1, 0, 0, 0, 1, 0);
        checkValue("rsp_drop_on_ack", 32'(rsp_req), 0);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkValue("fail_cleared", 32'(comm_fail), 0);

        // Frames during GAP and RSP are ignored: exactly one response.
        rises = 0; prev_req = 0;
        applyStimulus(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, (i == 1 || i == 5) ? 1'b1 : 1'b0, 0, (i == 7) ? 1'b1 : 1'b0, 0);
            if (rsp_req && !prev_req) rises++;
            prev_req = rsp_req;
        end
        checkValue("one_response", 32'(rises), 1);
        checkValue("err_untouched", 32'(dut.err_cnt), 0);

        // Corrupt frame coinciding with the timeout event counts once.
        for (int i = 0; i < 600 && m_cnt != 499; i++) runIdle(1);
        applyStimulus(1, 0, 1, 1, 0, 0);
        checkValue("err_coincide", 32'(dut.err_cnt), 1);
        checkValue("tmo_coincide", 32'(timeout_err), 1);

        // Three corrupt frames in a row.
        frameAndAck();
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        checkValue("fail_after_2_bad", 32'(comm_fail), 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        checkValue("fail_after_3_bad", 32'(comm_fail), 1);
        checkValue("no_rsp_on_bad", 32'(rsp_req), 0);

        // Disable while in RSP keeps comm-fail, clears the rest.
        applyStimulus(1, 0, 1, 0, 0, 0);
        runIdle(RSP_GAP_CYC);
        checkValue("in_rsp", 32'(rsp_req), 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkValue("dis_req", 32'(rsp_req), 0);
        checkValue("dis_tmo", 32'(timeout_err), 0);
        checkValue("dis_fail_kept", 32'(comm_fail), 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkValue("dis_fail_clr", 32'(comm_fail), 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 1);
        checkValue("set_beats_clr", 32'(comm_fail), 1);

        // Async reset in the middle of GAP.
        frameAndAck();
        applyStimulus(1, 0, 1, 0, 0, 0);
        runIdle(2);
        @(negedge i_clk);
        #2 rst_n = 1'b0;
        #1;
        checkValue("async_req",  32'(rsp_req),     0);
        checkValue("async_tmo",  32'(timeout_err), 0);
        checkValue("async_fail", 32'(comm_fail),   0);
        modelReset();
        releaseReset();

        // Config switched 0 -> 3 mid-count: timeout lands at 4000.
        for (int i = 1; i <= 4000; i++) begin
            applyStimulus(1, (i > 300) ? 2'd3 : 2'd0, 0, 0, 0, 0);
            if (i == 3999) checkValue("cfg3_before", 32'(timeout_err), 0);
            if (i == 4000) checkValue("cfg3_at_4000", 32'(timeout_err), 1);
        end

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic       en, rx, crc, ack, clr;
            logic [1:0] cfg;
            en  = ($urandom_range(0, 99) < 97);
            cfg = ($urandom_range(0, 499) == 0) ? 2'($urandom_range(0, 3)) : wdgtmo_config;
            rx  = ($urandom_range(0, 99) < 3);
            crc = ($urandom_range(0, 99) < 40);
            ack = ($urandom_range(0, 99) < 30);
            clr = ($urandom_range(0, 99) < 3);
            applyStimulus(en, cfg, rx, crc, ack, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/hv_wdg_ctrl.md
# hv_wdg_ctrl

HV-side watchdog responder, the far end of the LV watchdog OWT link. It checks that LV watchdog frames arrive within a configurable window and answers each valid frame with a response request to the HV OWT transmitter after a fixed turnaround gap. It also flags timeouts and escalates repeated errors to a sticky communication-fail. It sits between the HV OWT RX decoder, the HV OWT TX encoder and the HV fault/FSM logic.

## Interface
- WDG_CNT_W, 16, width of the timeout counter.
- RSP_GAP_CYC, 4, turnaround cycles between a valid frame and the response request; legal range 1..15.
- ERR_CNT_TH, 3, number of consecutive error events that sets comm-fail; legal range 1..7.
- END_OF_LIST, 1, list terminator, unused.

Ports:
- i_clk  in  1  block clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wdg_en  in  1  watchdog enable (level).
- i_wdgtmo_config  in  2  index into HV_WDG_TIMEOUT_TH.
- i_owt_rx_wdg_req  in  1  1-cycle pulse: LV watchdog frame decoded.
- i_owt_rx_crc_err  in  1  1-cycle pulse, qualifies the same-cycle frame as corrupt.
- o_wdg_owt_tx_rsp_req  out  1  response request to OWT TX (level until ack).
- i_owt_tx_wdg_rsp_ack  in  1  1-cycle ack from OWT TX.
- o_wdg_timeout_err  out  1  sticky timeout flag.
- o_wdg_comm_fail  out  1  sticky comm-fail flag.
- i_clr_comm_fail  in  1  1-cycle clear for o_wdg_comm_fail.

## Operation
**FSM states:** IDLE, WAIT, GAP, RSP.
- IDLE → WAIT when i_wdg_en=1.
- Any state → IDLE when i_wdg_en=0, taking effect next cycle.
  - Clears the timeout counter, gap counter, error counter, o_wdg_owt_tx_rsp_req and o_wdg_timeout_err.
  - Does not clear o_wdg_comm_fail.

**WAIT**
- Timeout counter increments each cycle.
- At cnt == HV_WDG_TIMEOUT_TH[i_wdgtmo_config]-1 a timeout event fires:
  - cnt wraps to 0;
  - o_wdg_timeout_err is set;
  - the error counter increments.
- Valid frame (rx_req=1, crc_err=0):
  - cnt → 0, o_wdg_timeout_err → 0, error counter → 0;
  - state → GAP.
- Corrupt frame (rx_req=1, crc_err=1):
  - the error counter increments;
  - state stays WAIT and cnt is not reset.
- Corrupt frame and timeout event in the same cycle: the error counter increments by 1, not 2.

**GAP**
- Gap counter runs 0..RSP_GAP_CYC-1, then state → RSP.

**RSP**
- o_wdg_owt_tx_rsp_req=1.
- On ack: request drops and state → WAIT with cnt=0.

**Rules for all states**
- Frames arriving in GAP/RSP are ignored, with no counter or flag effect.
- Ack while no request is pending is ignored.
- The error counter is 3 bits and saturates at 7.
- When error counter ≥ ERR_CNT_TH, o_wdg_comm_fail is set.
- i_clr_comm_fail clears o_wdg_comm_fail.
- Set and clear in the same cycle: set wins.
- Changing i_wdgtmo_config mid-count uses the new threshold immediately. If cnt is already above the new threshold-1, cnt counts on to wrap at 2^WDG_CNT_W with no event.

## Timing
- Reset values: state IDLE; all counters 0; o_wdg_owt_tx_rsp_req=0, o_wdg_timeout_err=0, o_wdg_comm_fail=0.
- All outputs are registered.
- **Timeout:** WAIT entered at cycle T (cnt=0) with no frame → timeout event in cycle T+TH-1, o_wdg_timeout_err=1 at T+TH.
- **Response:** valid frame sampled at cycle N → GAP at N+1 → o_wdg_owt_tx_rsp_req=1 at N+1+RSP_GAP_CYC.
- **Ack:** ack sampled at cycle A → request 0 and state WAIT (cnt=0) at A+1.
- **Comm-fail:** o_wdg_comm_fail rises the cycle after the event that brings the error counter to ERR_CNT_TH.
- **Enable:** i_wdg_en rising at cycle E → WAIT at E+1.

## Structure
- Shared package lv/hv param header (existing `include "lv_param.svh"` style) holds:
  - HV_WDG_TIMEOUT_TH[4] = {16'd4000, 16'd2000, 16'd1000, 16'd500}, where index 0 = 500;
  - the state enum hv_wdg_st_e.
- No sub-module. Single FSM plus three counters, roughly 180 lines.

## Test plan
- Config 0, enable, no frames → o_wdg_timeout_err=1 at 500 cycles after WAIT entry; error counter 1; after 3 timeouts o_wdg_comm_fail=1.
- Valid frame at cycle N (RSP_GAP_CYC=4) → o_wdg_owt_tx_rsp_req=1 at N+5; ack at N+8 → request 0 at N+9; timeout_err cleared at N+1.
- Corrupt frame in the same cycle as the timeout event → error counter +1 only. Three corrupt frames in a row → comm_fail=1 with no response request.
- Frame arriving during GAP and again during RSP → exactly one response, counters unchanged.
- Deassert i_wdg_en while in RSP → request 0 and state IDLE next cycle, timeout_err 0, comm_fail retained. i_clr_comm_fail asserted together with a new set event → comm_fail stays 1.
- Async reset mid-GAP → all outputs 0 immediately, IDLE after release; config switched 0→3 mid-count → timeout at 4000.
